mem_rd_arbiter: RTL and testbench
=================================

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning: 0 = round-robin between masters; 1 = dcache always wins ties.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ic_rd_req_valid  input  1  icache burst-read request valid.
REQ-005 ic_rd_req_addr  input  32  icache request address, 32-byte aligned.
REQ-006 ic_rd_req_ready  output  1  request accepted by memory on behalf of icache.
REQ-007 ic_rd_rsp_valid / ic_rd_rsp_data / ic_rd_rsp_last  output  1/32/1  response beat routed to icache.
REQ-008 ic_rd_rsp_ready  input  1  icache ready for current beat.
REQ-009 dc_rd_req_valid / dc_rd_req_addr  input  1/32  dcache burst-read request.
REQ-010 dc_rd_req_ready  output  1  request accepted on behalf of dcache.
REQ-011 dc_rd_rsp_valid / dc_rd_rsp_data / dc_rd_rsp_last  output  1/32/1  response beat routed to dcache.
REQ-012 dc_rd_rsp_ready  input  1  dcache ready for current beat.
REQ-013 mem_rd_req_valid / mem_rd_req_addr  output  1/32  single read request to memory.
REQ-014 mem_rd_req_ready  input  1  memory accepts request.
REQ-015 mem_rd_rsp_valid / mem_rd_rsp_data / mem_rd_rsp_last  input  1/32/1  memory response beat.
REQ-016 mem_rd_rsp_ready  output  1  arbiter ready for current memory beat.

Function
REQ-017 SHALL implement one-hot FSM IDLE, REQ, RSP; exactly one burst outstanding at a time.
REQ-018 IDLE: if any req_valid, SHALL grant one master, latch owner flag and its address, go REQ next cycle; else stay IDLE.
REQ-019 Grant: only one valid -> that master; both valid -> FIXED_PRIO=1: dcache; FIXED_PRIO=0: master not granted last time (last-grant pointer updated on every grant).
REQ-020 REQ: mem_rd_req_valid=1, mem_rd_req_addr=latched address; owner's rd_req_ready = mem_rd_req_ready (combinational), other master's rd_req_ready=0; on mem_rd_req_ready go RSP.
REQ-021 Masters hold valid/addr stable until their rd_req_ready; arbiter SHALL use only latched address in REQ/RSP.
REQ-022 RSP: owner's rsp_valid/data/last = mem_rd_rsp_valid/data/last; mem_rd_rsp_ready = owner's rsp_ready; non-owner rsp_valid=0, rsp_last=0, rsp_data=0.
REQ-023 RSP: on mem_rd_rsp_valid & mem_rd_rsp_ready & mem_rd_rsp_last go IDLE; beats without last keep RSP; any beat count accepted.
REQ-024 Outside RSP, mem_rd_rsp_ready=0 and both rsp_valid=0; outside REQ, mem_rd_req_valid=0 and both req_ready=0.
REQ-025 Minimum turnaround: grant cycle in IDLE, request visible next cycle; new grant no earlier than cycle after last beat.
REQ-026 Request arriving while busy SHALL wait, not be dropped; non-owner may keep valid asserted indefinitely.
REQ-027 Simultaneous last beat and new req_valid: stay on transition to IDLE; grant decided in IDLE next cycle.

Reset
REQ-028 rst SHALL force IDLE, clear owner, set last-grant pointer to icache (so dcache wins first tie), all outputs 0 by next edge.
REQ-029 rst mid-REQ or mid-RSP SHALL abandon burst; remaining memory beats after reset not forwarded (mem_rd_rsp_ready=0 in IDLE).

Verification
REQ-030 Only ic valid, addr 0x0000_1000, mem ready 1 cycle later, 8 beats 0xA0..0xA7 last on 8th -> mem addr 0x0000_1000, icache gets 8 beats, dcache rsp_valid never 1, IDLE after.
REQ-031 Both valid same cycle, FIXED_PRIO=0, after reset -> dcache served first, then icache; repeat both valid -> grants alternate ic/dc.
REQ-032 FIXED_PRIO=1, both valid continuously for 3 bursts -> dcache wins every tie; icache served only when dc_rd_req_valid low in IDLE.
REQ-033 Owner rsp_ready low for 3 cycles mid-burst -> mem_rd_rsp_ready low those cycles, no beat lost or duplicated, data order preserved.
REQ-034 Assert rst after 4th beat of 8 -> IDLE next cycle, outputs 0, subsequent beats ignored; new ic request afterwards served normally.

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// Two-master burst-read arbiter: icache and dcache share one memory read port,
// one burst outstanding at a time, round-robin or fixed dcache priority.
module mem_rd_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ic_rd_req_valid,
    input  logic [31:0] ic_rd_req_addr,
    output logic        ic_rd_req_ready,
    output logic        ic_rd_rsp_valid,
    output logic [31:0] ic_rd_rsp_data,
    output logic        ic_rd_rsp_last,
    input  logic        ic_rd_rsp_ready,

    input  logic        dc_rd_req_valid,
    input  logic [31:0] dc_rd_req_addr,
    output logic        dc_rd_req_ready,
    output logic        dc_rd_rsp_valid,
    output logic [31:0] dc_rd_rsp_data,
    output logic        dc_rd_rsp_last,
    input  logic        dc_rd_rsp_ready,

    output logic        mem_rd_req_valid,
    output logic [31:0] mem_rd_req_addr,
    input  logic        mem_rd_req_ready,
    input  logic        mem_rd_rsp_valid,
    input  logic [31:0] mem_rd_rsp_data,
    input  logic        mem_rd_rsp_last,
    output logic        mem_rd_rsp_ready,

    output logic [2:0]  dbg_state
);

    // Handshake rule on every channel: a transfer happens in a cycle where
    // valid and ready are both high; valid and its payload stay stable until then.

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        RSP  = 3'b100
    } state_t;

    state_t      state_q, state_d;
    logic        owner_dc_q, owner_dc_d;
    logic        last_dc_q, last_dc_d;
    logic [31:0] addr_q, addr_d;
    logic        grant_dc;
    logic        owner_rsp_ready;

    // On a tie, dcache wins if fixed priority or if icache was granted last.
    assign grant_dc = dc_rd_req_valid &&
                      (!ic_rd_req_valid || FIXED_PRIO || !last_dc_q);

    assign owner_rsp_ready = owner_dc_q ? dc_rd_rsp_ready : ic_rd_rsp_ready;
    assign dbg_state       = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_dc_q <= 1'b0;
            last_dc_q  <= 1'b0;
            addr_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            owner_dc_q <= owner_dc_d;
            last_dc_q  <= last_dc_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        owner_dc_d       = owner_dc_q;
        last_dc_d        = last_dc_q;
        addr_d           = addr_q;
        ic_rd_req_ready  = 1'b0;
        dc_rd_req_ready  = 1'b0;
        ic_rd_rsp_valid  = 1'b0;
        ic_rd_rsp_data   = 32'h0;
        ic_rd_rsp_last   = 1'b0;
        dc_rd_rsp_valid  = 1'b0;
        dc_rd_rsp_data   = 32'h0;
        dc_rd_rsp_last   = 1'b0;
        mem_rd_req_valid = 1'b0;
        mem_rd_req_addr  = 32'h0;
        mem_rd_rsp_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (ic_rd_req_valid || dc_rd_req_valid) begin
                    owner_dc_d = grant_dc;
                    last_dc_d  = grant_dc;
                    addr_d     = grant_dc ? dc_rd_req_addr : ic_rd_req_addr;
                    state_d    = REQ;
                end
            end
            REQ: begin
                mem_rd_req_valid = 1'b1;
                mem_rd_req_addr  = addr_q;
                ic_rd_req_ready  = !owner_dc_q && mem_rd_req_ready;
                dc_rd_req_ready  = owner_dc_q && mem_rd_req_ready;
                if (mem_rd_req_ready) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                mem_rd_rsp_ready = owner_rsp_ready;
                if (owner_dc_q) begin
                    dc_rd_rsp_valid = mem_rd_rsp_valid;
                    dc_rd_rsp_data  = mem_rd_rsp_data;
                    dc_rd_rsp_last  = mem_rd_rsp_last;
                end else begin
                    ic_rd_rsp_valid = mem_rd_rsp_valid;
                    ic_rd_rsp_data  = mem_rd_rsp_data;
                    ic_rd_rsp_last  = mem_rd_rsp_last;
                end
                // The next grant is decided in IDLE, never in the last-beat cycle.
                if (mem_rd_rsp_valid && owner_rsp_ready && mem_rd_rsp_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: one round-robin and one fixed-priority instance,
// bench-side memory/master models and a transaction-level grant model.
module tb_mem_rd_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: FIXED_PRIO=0, index 1: FIXED_PRIO=1
    logic [1:0]  rst;
    logic [1:0]  ic_req_valid, ic_req_ready, ic_rsp_valid, ic_rsp_last, ic_rsp_ready;
    logic [1:0]  dc_req_valid, dc_req_ready, dc_rsp_valid, dc_rsp_last, dc_rsp_ready;
    logic [1:0]  mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_last, mem_rsp_ready;
    logic [31:0] ic_req_addr[2], ic_rsp_data[2], dc_req_addr[2], dc_rsp_data[2];
    logic [31:0] mem_req_addr[2], mem_rsp_data[2];
    logic [2:0]  dbg_state[2];

    int n_cmp = 0;
    int n_err = 0;
    bit last_dc[2];
    logic [31:0] exp_q[$];

    mem_rd_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst[0]),
        .ic_rd_req_valid(ic_req_valid[0]), .ic_rd_req_addr(ic_req_addr[0]),
        .ic_rd_req_ready(ic_req_ready[0]), .ic_rd_rsp_valid(ic_rsp_valid[0]),
        .ic_rd_rsp_data(ic_rsp_data[0]), .ic_rd_rsp_last(ic_rsp_last[0]),
        .ic_rd_rsp_ready(ic_rsp_ready[0]),
        .dc_rd_req_valid(dc_req_valid[0]), .dc_rd_req_addr(dc_req_addr[0]),
        .dc_rd_req_ready(dc_req_ready[0]), .dc_rd_rsp_valid(dc_rsp_valid[0]),
        .dc_rd_rsp_data(dc_rsp_data[0]), .dc_rd_rsp_last(dc_rsp_last[0]),
        .dc_rd_rsp_ready(dc_rsp_ready[0]),
        .mem_rd_req_valid(mem_req_valid[0]), .mem_rd_req_addr(mem_req_addr[0]),
        .mem_rd_req_ready(mem_req_ready[0]), .mem_rd_rsp_valid(mem_rsp_valid[0]),
        .mem_rd_rsp_data(mem_rsp_data[0]), .mem_rd_rsp_last(mem_rsp_last[0]),
        .mem_rd_rsp_ready(mem_rsp_ready[0]), .dbg_state(dbg_state[0])
    );

    mem_rd_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst(rst[1]),
        .ic_rd_req_valid(ic_req_valid[1]), .ic_rd_req_addr(ic_req_addr[1]),
        .ic_rd_req_ready(ic_req_ready[1]), .ic_rd_rsp_valid(ic_rsp_valid[1]),
        .ic_rd_rsp_data(ic_rsp_data[1]), .ic_rd_rsp_last(ic_rsp_last[1]),
        .ic_rd_rsp_ready(ic_rsp_ready[1]),
        .dc_rd_req_valid(dc_req_valid[1]), .dc_rd_req_addr(dc_req_addr[1]),
        .dc_rd_req_ready(dc_req_ready[1]), .dc_rd_rsp_valid(dc_rsp_valid[1]),
        .dc_rd_rsp_data(dc_rsp_data[1]), .dc_rd_rsp_last(dc_rsp_last[1]),
        .dc_rd_rsp_ready(dc_rsp_ready[1]),
        .mem_rd_req_valid(mem_req_valid[1]), .mem_rd_req_addr(mem_req_addr[1]),
        .mem_rd_req_ready(mem_req_ready[1]), .mem_rd_rsp_valid(mem_rsp_valid[1]),
        .mem_rd_rsp_data(mem_rsp_data[1]), .mem_rd_rsp_last(mem_rsp_last[1]),
        .mem_rd_rsp_ready(mem_rsp_ready[1]), .dbg_state(dbg_state[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All interface outputs low, FSM in IDLE
    task automatic chk_quiet(input int p, input string tag);
        chk({tag, "_req"}, 64'({mem_req_valid[p], ic_req_ready[p], dc_req_ready[p]}), 64'd0);
        chk({tag, "_rspv"}, 64'({ic_rsp_valid[p], dc_rsp_valid[p], mem_rsp_ready[p],
                                  ic_rsp_last[p], dc_rsp_last[p]}), 64'd0);
        chk({tag, "_data"}, {ic_rsp_data[p], dc_rsp_data[p]}, 64'd0);
        chk({tag, "_addr"}, 64'(mem_req_addr[p]), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state[p]), 64'd1);
    endtask

    task automatic clear_inputs(input int p);
        ic_req_valid[p] = 1'b0; dc_req_valid[p] = 1'b0;
        ic_req_addr[p] = 32'h0; dc_req_addr[p] = 32'h0;
        ic_rsp_ready[p] = 1'b0; dc_rsp_ready[p] = 1'b0;
        mem_req_ready[p] = 1'b0; mem_rsp_valid[p] = 1'b0;
        mem_rsp_data[p] = 32'h0; mem_rsp_last[p] = 1'b0;
    endtask

    task automatic do_reset(input int p);
        clear_inputs(p);
        rst[p] = 1'b1;
        @(posedge clk); #1;
        rst[p] = 1'b0;
        last_dc[p] = 1'b0;
        #1;
        chk_quiet(p, "reset");
    endtask

    task automatic raise(input int p, input bit dc);
        if (dc) begin
            dc_req_valid[p] = 1'b1;
            dc_req_addr[p] = $urandom() & 32'hFFFF_FFE0;
        end else begin
            ic_req_valid[p] = 1'b1;
            ic_req_addr[p] = $urandom() & 32'hFFFF_FFE0;
        end
    endtask

    // Grant rule: lone requester wins; tie goes to dcache under fixed priority,
    // otherwise to whichever master was not granted last.
    function automatic bit pick_dc(input int p);
        if (!dc_req_valid[p]) return 1'b0;
        if (!ic_req_valid[p]) return 1'b1;
        if (p == 1) return 1'b1;
        return !last_dc[p];
    endfunction

    // Called in the IDLE cycle with requests already driven. Serves one burst
    // of n beats with data base+k; abort_after>0 resets after that many beats.
    task automatic burst(input int p, input int n, input logic [31:0] base, input bit rnd,
                         input int stall_at, input int abort_after, input bit exp_dc);
        bit w_dc, accepted, stall_done;
        logic [31:0] w_addr, e, o_data, x_data;
        logic o_valid, o_last, o_ready, x_valid, x_last;
        int i, got, cnt, stall_left;

        w_dc = pick_dc(p);
        chk("grant_owner", 64'(w_dc), 64'(exp_dc));
        w_addr = w_dc ? dc_req_addr[p] : ic_req_addr[p];
        last_dc[p] = w_dc;
        #1;
        chk("grant_cycle_quiet", 64'({mem_req_valid[p], ic_req_ready[p], dc_req_ready[p],
                                      mem_rsp_ready[p]}), 64'd0);
        @(posedge clk); #1;

        accepted = 1'b0;
        cnt = 0;
        while (!accepted && cnt < 20) begin
            mem_req_ready[p] = rnd ? ((cnt >= 3) || ($urandom_range(0, 2) == 0)) : (cnt >= 1);
            #1;
            chk("req_valid", 64'(mem_req_valid[p]), 64'd1);
            chk("req_addr", 64'(mem_req_addr[p]), 64'(w_addr));
            chk("own_req_ready", 64'(w_dc ? dc_req_ready[p] : ic_req_ready[p]),
                64'(mem_req_ready[p]));
            chk("oth_req_ready", 64'(w_dc ? ic_req_ready[p] : dc_req_ready[p]), 64'd0);
            chk("req_rsp_quiet", 64'({ic_rsp_valid[p], dc_rsp_valid[p], mem_rsp_ready[p]}), 64'd0);
            accepted = mem_req_ready[p];
            @(posedge clk); #1;
            cnt++;
        end
        mem_req_ready[p] = 1'b0;
        if (w_dc) dc_req_valid[p] = 1'b0; else ic_req_valid[p] = 1'b0;

        for (int k = 0; k < n; k++) exp_q.push_back(base + k);
        i = 0; got = 0; cnt = 0; stall_left = 0; stall_done = 1'b0;
        while (got < n && cnt < 300) begin
            if (abort_after > 0 && got == abort_after) break;
            if (stall_at >= 0 && !stall_done && got == stall_at) begin
                stall_left = 3;
                stall_done = 1'b1;
            end
            mem_rsp_valid[p] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            mem_rsp_data[p]  = base + i;
            mem_rsp_last[p]  = (i == n - 1);
            o_ready = (stall_left > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (stall_left > 0) stall_left--;
            ic_rsp_ready[p] = w_dc ? 1'($urandom_range(0, 1)) : o_ready;
            dc_rsp_ready[p] = w_dc ? o_ready : 1'($urandom_range(0, 1));
            #1;
            o_valid = w_dc ? dc_rsp_valid[p] : ic_rsp_valid[p];
            o_data  = w_dc ? dc_rsp_data[p]  : ic_rsp_data[p];
            o_last  = w_dc ? dc_rsp_last[p]  : ic_rsp_last[p];
            x_valid = w_dc ? ic_rsp_valid[p] : dc_rsp_valid[p];
            x_data  = w_dc ? ic_rsp_data[p]  : dc_rsp_data[p];
            x_last  = w_dc ? ic_rsp_last[p]  : dc_rsp_last[p];
            chk("rsp_mem_ready", 64'(mem_rsp_ready[p]), 64'(o_ready));
            chk("rsp_valid", 64'(o_valid), 64'(mem_rsp_valid[p]));
            chk("oth_rsp", {30'd0, x_valid, x_last, x_data}, 64'd0);
            chk("rsp_req_quiet", 64'({mem_req_valid[p], ic_req_ready[p], dc_req_ready[p]}), 64'd0);
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_extra_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 64'(o_data), 64'(e));
                    chk("rsp_last", 64'(o_last), 64'(exp_q.size() == 0));
                    got++;
                end
            end
            if (mem_rsp_valid[p] && mem_rsp_ready[p]) i++;
            @(posedge clk); #1;
            cnt++;
        end

        if (abort_after > 0 && got == abort_after) begin
            rst[p] = 1'b1;
            mem_rsp_valid[p] = 1'b1;
            mem_rsp_data[p] = base + i;
            mem_rsp_last[p] = 1'b0;
            @(posedge clk); #1;
            rst[p] = 1'b0;
            last_dc[p] = 1'b0;
            exp_q.delete();
            for (int c = 0; c < 4; c++) begin
                mem_rsp_data[p] = base + i + c;
                mem_rsp_last[p] = (c == 3);
                #1;
                chk_quiet(p, "abort");
                @(posedge clk); #1;
            end
        end else begin
            chk("burst_beats", 64'(got), 64'(n));
            chk("burst_leftover", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        mem_rsp_valid[p] = 1'b0; mem_rsp_last[p] = 1'b0; mem_rsp_data[p] = 32'h0;
        ic_rsp_ready[p] = 1'b0; dc_rsp_ready[p] = 1'b0;
        #1;
        chk("after_burst_idle", 64'(dbg_state[p]), 64'd1);
        chk("after_burst_rsp_ready", 64'(mem_rsp_ready[p]), 64'd0);
    endtask

    initial begin
        bit want_dc;
        rst = 2'b11;
        clear_inputs(0);
        clear_inputs(1);
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;
        last_dc[0] = 1'b0;
        last_dc[1] = 1'b0;
        #1;
        chk_quiet(0, "por0");
        chk_quiet(1, "por1");

        // Lone icache burst with fixed data pattern
        ic_req_valid[0] = 1'b1;
        ic_req_addr[0] = 32'h0000_1000;
        burst(0, 8, 32'hA0, 1'b0, -1, 0, 1'b0);

        // Round-robin: dcache first after reset, then alternation
        do_reset(0);
        raise(0, 1'b0);
        raise(0, 1'b1);
        want_dc = 1'b1;
        for (int b = 0; b < 4; b++) begin
            burst(0, 2 + b, $urandom(), 1'b0, -1, 0, want_dc);
            if (want_dc) raise(0, 1'b1); else raise(0, 1'b0);
            want_dc = !want_dc;
        end
        burst(0, 1, $urandom(), 1'b0, -1, 0, want_dc);

        // Fixed priority: dcache wins three ties, icache only when dcache idle
        do_reset(1);
        raise(1, 1'b0);
        raise(1, 1'b1);
        for (int b = 0; b < 3; b++) begin
            burst(1, 4, $urandom(), 1'b0, -1, 0, 1'b1);
            if (b < 2) raise(1, 1'b1);
        end
        burst(1, 4, $urandom(), 1'b0, -1, 0, 1'b0);

        // Owner back-pressure for 3 cycles mid-burst
        do_reset(0);
        raise(0, 1'b1);
        burst(0, 8, 32'h5500, 1'b0, 3, 0, 1'b1);

        // Random traffic on both instances
        for (int p = 0; p < 2; p++) begin
            do_reset(p);
            for (int b = 0; b < 20; b++) begin
                if (!ic_req_valid[p] && $urandom_range(0, 1) == 1) raise(p, 1'b0);
                if (!dc_req_valid[p] && $urandom_range(0, 1) == 1) raise(p, 1'b1);
                if (!ic_req_valid[p] && !dc_req_valid[p]) raise(p, 1'($urandom_range(0, 1)));
                want_dc = dc_req_valid[p] && (!ic_req_valid[p] || p == 1 || !last_dc[p]);
                burst(p, $urandom_range(1, 8), $urandom(), 1'b1, -1, 0, want_dc);
            end
        end

        // Reset after the 4th of 8 beats, then a normal icache burst
        do_reset(0);
        raise(0, 1'b0);
        burst(0, 8, 32'hC0, 1'b0, -1, 4, 1'b0);
        raise(0, 1'b0);
        burst(0, 8, 32'hD0, 1'b0, -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
